// File: rtl/bin2bcd_if.sv
// Request/response bundle between a conversion requester and the bin2bcd block.
// The requester holds ap_start until it sees ap_done; results stay on
// ap_return/ndigits until the next conversion finishes.
interface bin2bcd_if;
    logic        ap_start;
    logic [31:0] bin;
    logic        ap_ready;
    logic        ap_done;
    logic [39:0] ap_return;
    logic [3:0]  ndigits;

    modport master (
        output ap_start, bin,
        input  ap_ready, ap_done, ap_return, ndigits
    );

    modport slave (
        input  ap_start, bin,
        output ap_ready, ap_done, ap_return, ndigits
    );
endinterface

// File: rtl/bin2bcd.sv
// Sequential 32-bit binary to 10-digit packed BCD converter (double dabble).
// One bit is shifted in per cycle: accept edge, 32 shift edges, one finish
// edge, so the result appears 33 cycles after the accepting edge.
module bin2bcd (
    input  logic     ap_clk,
    input  logic     ap_rst,
    bin2bcd_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, FIN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] sh, sh_nxt;          // remaining binary bits, MSB first
    logic [39:0] acc, acc_nxt;        // BCD accumulator being built
    logic [39:0] acc_adj;             // accumulator after add-3 correction
    logic [5:0]  cnt, cnt_nxt;        // completed shift iterations
    logic        ready, ready_nxt;
    logic        done, done_nxt;
    logic [39:0] ret, ret_nxt;
    logic [3:0]  nd, nd_nxt, nd_calc;

    assign bus.ap_ready  = ready;
    assign bus.ap_done   = done;
    assign bus.ap_return = ret;
    assign bus.ndigits   = nd;

    // Add 3 to every nibble that is 5 or more so the following doubling carries into the next digit.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 10; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    // Significant digit count: position of the highest non-zero nibble plus one, minimum one.
    always_comb begin
        nd_calc = 4'd1;
        for (int i = 1; i < 10; i++) begin
            if (acc[4*i +: 4] != 4'd0)
                nd_calc = 4'(i + 1);
        end
    end

    // Next-state and next-register values for the handshake FSM and datapath.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves one unassigned and infers a latch.
        state_nxt = state;
        sh_nxt    = sh;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ready_nxt = 1'b0;
        done_nxt  = done;
        ret_nxt   = ret;
        nd_nxt    = nd;
        unique case (state)
            IDLE: begin
                if (bus.ap_start) begin
                    sh_nxt    = bus.bin;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end else begin
                    ready_nxt = 1'b1;
                end
            end
            SHIFT: begin
                acc_nxt = {acc_adj[38:0], sh[31]};
                sh_nxt  = {sh[30:0], 1'b0};
                cnt_nxt = cnt + 6'd1;
                if (cnt == 6'd31)
                    state_nxt = FIN;
            end
            FIN: begin
                ret_nxt   = acc;
                nd_nxt    = nd_calc;
                done_nxt  = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                // Stay here while the requester still holds ap_start so a held
                // request is not mistaken for a new one.
                if (!bus.ap_start) begin
                    done_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= IDLE;
            sh    <= '0;
            acc   <= '0;
            cnt   <= '0;
            ready <= 1'b0;
            done  <= 1'b0;
            ret   <= '0;
            nd    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state <= state_nxt;
            sh    <= sh_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ready <= ready_nxt;
            done  <= done_nxt;
            ret   <= ret_nxt;
            nd    <= nd_nxt;
        end
    end
endmodule

// File: tb/tb_bin2bcd.sv
// Bench for bin2bcd: directed conversions with hand-computed BCD results.
// The stimulus pushes each expected result into a queue; a separate monitor
// pops and compares on every rising ap_done.
module tb_bin2bcd;
    logic ap_clk;
    logic ap_rst;
    bin2bcd_if bus();

    bin2bcd dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    typedef struct packed {
        logic [39:0] ret;
        logic [3:0]  nd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare each completed conversion against the oldest expectation.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (bus.ap_done && !prev_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("ap_return", bus.ap_return, e.ret);
                    check("ndigits", bus.ndigits, e.nd);
                end
            end
            prev_done = bus.ap_done;
        end
    end

    // Start a conversion from IDLE and check handshake timing up to ap_done.
    // drop_at/chg_at: SHIFT cycle after which ap_start is released / bin is altered (0 = never).
    task automatic start_conv(input logic [31:0] b, input logic [39:0] er, input logic [3:0] en,
                              input int drop_at, input int chg_at);
        exp_t e;
        logic bad_ready, early_done;
        e.ret = er;
        e.nd  = en;
        bus.bin      = b;
        bus.ap_start = 1'b1;
        sb.push_back(e);
        @(posedge ap_clk); #1;   // accepting edge E0
        check("ready_low_after_accept", bus.ap_ready, 64'd0);
        bad_ready  = 1'b0;
        early_done = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            @(posedge ap_clk); #1;
            if (bus.ap_ready) bad_ready = 1'b1;
            if (c < 33 && bus.ap_done) early_done = 1'b1;
            if (c == drop_at) bus.ap_start = 1'b0;
            if (c == chg_at)  bus.bin = ~b;
        end
        check("ready_low_during_conv", bad_ready, 64'd0);
        check("done_not_early", early_done, 64'd0);
        check("done_at_latency_33", bus.ap_done, 64'd1);
    endtask

    // Release ap_start and check the DONE -> IDLE -> ready sequence.
    task automatic finish_conv();
        bus.ap_start = 1'b0;
        @(posedge ap_clk); #1;
        check("done_one_cycle", bus.ap_done, 64'd0);
        check("ready_still_low", bus.ap_ready, 64'd0);
        @(posedge ap_clk); #1;
        check("ready_back_high", bus.ap_ready, 64'd1);
    endtask

    initial begin
        logic bad;
        int   waited;
        ap_rst       = 1'b1;
        bus.ap_start = 1'b0;
        bus.bin      = 32'd0;
        #12;
        check("rst_ready", bus.ap_ready, 64'd0);
        check("rst_done", bus.ap_done, 64'd0);
        check("rst_return", bus.ap_return, 64'd0);
        check("rst_ndigits", bus.ndigits, 64'd0);
        ap_rst = 1'b0;
        @(posedge ap_clk); #1;
        check("ready_after_release", bus.ap_ready, 64'd1);

        // Zero: held start, then held in DONE for two cycles.
        start_conv(32'd0, 40'h0, 4'd1, 0, 0);
        repeat (2) begin
            @(posedge ap_clk); #1;
            check("done_held", bus.ap_done, 64'd1);
        end
        finish_conv();

        // Maximum input, all ten digits.
        start_conv(32'hFFFF_FFFF, 40'h42_9496_7295, 4'd10, 0, 0);
        finish_conv();

        // Back-to-back requests from the upstream x10 stage.
        start_conv(32'd10, 40'h10, 4'd2, 0, 0);
        finish_conv();
        start_conv(32'd1234560, 40'h123_4560, 4'd7, 0, 0);
        finish_conv();

        // ap_start dropped in SHIFT and bin altered after accept: both ignored.
        start_conv(32'd987654321, 40'h09_8765_4321, 4'd9, 5, 3);
        finish_conv();

        // Reset in the middle of SHIFT aborts the conversion and clears outputs.
        bus.bin      = 32'd12345678;
        bus.ap_start = 1'b1;
        @(posedge ap_clk); #1;
        repeat (16) @(posedge ap_clk);
        #2;
        ap_rst = 1'b1;
        #1;
        check("midrst_ready", bus.ap_ready, 64'd0);
        check("midrst_done", bus.ap_done, 64'd0);
        check("midrst_return", bus.ap_return, 64'd0);
        check("midrst_ndigits", bus.ndigits, 64'd0);
        bus.ap_start = 1'b0;
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        @(posedge ap_clk); #1;
        check("ready_after_midrst", bus.ap_ready, 64'd1);
        start_conv(32'd99, 40'h99, 4'd2, 0, 0);
        finish_conv();

        // Held in DONE for ten cycles with a new bin: no new accept, result stable.
        start_conv(32'd4321, 40'h4321, 4'd4, 0, 0);
        bus.bin = 32'd777;
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge ap_clk); #1;
            if (!bus.ap_done || bus.ap_ready || bus.ap_return !== 40'h4321) bad = 1'b1;
        end
        check("done_hold_10_stable", bad, 64'd0);
        check("done_hold_return", bus.ap_return, 64'h4321);
        finish_conv();
        check("return_kept_in_idle", bus.ap_return, 64'h4321);
        start_conv(32'd777, 40'h777, 4'd3, 0, 0);
        finish_conv();

        // Reset released while ap_start is already high: accepted on the first edge.
        ap_rst       = 1'b1;
        bus.bin      = 32'd55;
        bus.ap_start = 1'b1;
        #1;
        check("rst_clears_return", bus.ap_return, 64'd0);
        #1;
        ap_rst = 1'b0;
        start_conv(32'd55, 40'h55, 4'd2, 0, 0);
        finish_conv();

        // Drain: every expectation must have been consumed by the monitor.
        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(posedge ap_clk);
            waited++;
        end
        check("scoreboard_empty", sb.size(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
